// File: rtl/inv_fb_pkg.sv
// ----------------------------------------------------------------------------
// inv_fb_pkg
// Shared types and default constants for the inverter feedback qualifier.
//   fb_state_e : sequencer states (IDLE, SETTLE, ACCUM, DECIDE, LOCKED)
//   fb_dir_e   : decision direction (NONE, UP, DOWN)
//   DEF_*      : default values for the inv_fb_filter parameters
// ----------------------------------------------------------------------------
package inv_fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_LOCKED = 3'd4
  } fb_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } fb_dir_e;

  localparam int unsigned DEF_WIN_LEN    = 16;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_THRESH     = 4;
  localparam int unsigned DEF_LOCK_REV   = 3;

  // A step counts as a reversal only against an established opposite direction.
  function automatic logic is_reversal(input fb_dir_e last_dir, input fb_dir_e new_dir);
    logic rev;
    rev = 1'b0;
    if ((last_dir == DIR_UP) && (new_dir == DIR_DOWN)) begin
      rev = 1'b1;
    end else if ((last_dir == DIR_DOWN) && (new_dir == DIR_UP)) begin
      rev = 1'b1;
    end else begin
      rev = 1'b0;
    end
    return rev;
  endfunction

endpackage

// File: rtl/inv_fb_sync2.sv
// ----------------------------------------------------------------------------
// inv_fb_sync2
// Two-flop synchronizer for one asynchronous comparator bit.
// Ports:
//   CLK : clock (posedge)
//   RST : synchronous active-high reset, clears both flops
//   D   : asynchronous input
//   Q   : synchronized output, two cycles behind D
// ----------------------------------------------------------------------------
module inv_fb_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= D;
      sync_r <= meta_r;
    end
  end

  assign Q = sync_r;

endmodule

// File: rtl/inv_fb_filter.sv
// ----------------------------------------------------------------------------
// inv_fb_filter
// Feedback qualifier in front of the 4-bit inverter configuration stage.
// Synchronizes the comparator pair, integrates it over WIN_LEN samples and
// issues at most one single-cycle step request per window, followed by an
// analog settle interval of SETTLE_CYC cycles.
//
// Optional build macro: INV_FB_LOCK_EN
//   defined   : after LOCK_REV consecutive direction reversals the step is
//               suppressed, LOCKED rises and stepping stops until RST.
//   undefined : LOCKED is tied low and the sequencer cycles indefinitely.
//
// Ports:
//   CLK    : clock, all logic on posedge
//   RST    : synchronous active-high reset
//   EN     : loop enable, low returns to IDLE
//   CMP_U  : raw "pull up" comparator, asynchronous
//   CMP_D  : raw "pull down" comparator, asynchronous
//   O_INVU : one-cycle step-up request
//   O_INVD : one-cycle step-down request
//   BAL    : one-cycle pulse, window balanced, no step
//   LOCKED : level, dither lock declared
// ----------------------------------------------------------------------------
module inv_fb_filter
  import inv_fb_pkg::*;
#(
  parameter int unsigned WIN_LEN    = DEF_WIN_LEN,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned THRESH     = DEF_THRESH,
  parameter int unsigned LOCK_REV   = DEF_LOCK_REV
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CMP_U,
  input  logic CMP_D,
  output logic O_INVU,
  output logic O_INVD,
  output logic BAL,
  output logic LOCKED
);

  localparam int unsigned CW = $clog2(WIN_LEN + 1);
  localparam int unsigned AW = $clog2(WIN_LEN);
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [AW-1:0] ACC_LAST    = AW'(WIN_LEN - 1);
  localparam logic [CW:0]   THR_EXT     = (CW + 1)'(THRESH);

  fb_state_e     state_r;
  logic [SW-1:0] settle_cnt_r;
  logic [AW-1:0] acc_cnt_r;
  logic [CW-1:0] up_cnt_r;
  logic [CW-1:0] dn_cnt_r;
  logic          invu_r;
  logic          invd_r;
  logic          bal_r;

  logic          u_sync_s;
  logic          d_sync_s;
  logic [CW:0]   up_ext_s;
  logic [CW:0]   dn_ext_s;
  fb_dir_e       dir_s;

  inv_fb_sync2 u_sync_u (
    .CLK (CLK),
    .RST (RST),
    .D   (CMP_U),
    .Q   (u_sync_s)
  );

  inv_fb_sync2 u_sync_d (
    .CLK (CLK),
    .RST (RST),
    .D   (CMP_D),
    .Q   (d_sync_s)
  );

  // One extra bit so count + THRESH can never wrap.
  assign up_ext_s = {1'b0, up_cnt_r};
  assign dn_ext_s = {1'b0, dn_cnt_r};

  // Window decision from the accumulated counts.
  always_comb begin
    dir_s = DIR_NONE;
    if (up_ext_s >= (dn_ext_s + THR_EXT)) begin
      dir_s = DIR_UP;
    end else if (dn_ext_s >= (up_ext_s + THR_EXT)) begin
      dir_s = DIR_DOWN;
    end else begin
      dir_s = DIR_NONE;
    end
  end

`ifdef INV_FB_LOCK_EN
  localparam int unsigned RW = $clog2(LOCK_REV + 1);

  fb_dir_e       last_dir_r;
  logic [RW-1:0] rev_cnt_r;
  logic          locked_r;
  fb_dir_e       last_next_s;
  logic [RW-1:0] rev_next_s;
  logic          lock_hit_s;

  // Reversal bookkeeping for the decision being made this cycle.
  always_comb begin
    last_next_s = last_dir_r;
    rev_next_s  = rev_cnt_r;
    if (dir_s == DIR_NONE) begin
      last_next_s = last_dir_r;
      rev_next_s  = rev_cnt_r;
    end else if (is_reversal(last_dir_r, dir_s)) begin
      last_next_s = dir_s;
      rev_next_s  = rev_cnt_r + RW'(1);
    end else begin
      last_next_s = dir_s;
      rev_next_s  = {RW{1'b0}};
    end
  end

  // rev_cnt stops at LOCK_REV because reaching it ends stepping.
  assign lock_hit_s = (dir_s != DIR_NONE) && (rev_next_s == RW'(LOCK_REV));

  // Direction history and sticky lock flag; only RST releases the lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_dir_r <= DIR_NONE;
      rev_cnt_r  <= {RW{1'b0}};
      locked_r   <= 1'b0;
    end else if (!EN) begin
      last_dir_r <= DIR_NONE;
      rev_cnt_r  <= {RW{1'b0}};
      locked_r   <= locked_r;
    end else if (state_r == ST_DECIDE) begin
      last_dir_r <= last_next_s;
      rev_cnt_r  <= rev_next_s;
      locked_r   <= locked_r | lock_hit_s;
    end else begin
      last_dir_r <= last_dir_r;
      rev_cnt_r  <= rev_cnt_r;
      locked_r   <= locked_r;
    end
  end

  assign LOCKED = locked_r;
`else
  assign LOCKED = 1'b0;
`endif

  // Sequencer with registered single-cycle decision pulses.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SW{1'b0}};
      acc_cnt_r    <= {AW{1'b0}};
      up_cnt_r     <= {CW{1'b0}};
      dn_cnt_r     <= {CW{1'b0}};
      invu_r       <= 1'b0;
      invd_r       <= 1'b0;
      bal_r        <= 1'b0;
    end else begin
      invu_r <= 1'b0;
      invd_r <= 1'b0;
      bal_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
`ifdef INV_FB_LOCK_EN
          if (locked_r) begin
            state_r <= ST_LOCKED;
          end else begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= SETTLE_LOAD;
          end
`else
          state_r      <= ST_SETTLE;
          settle_cnt_r <= SETTLE_LOAD;
`endif
        end
        ST_SETTLE: begin
          if (settle_cnt_r == {SW{1'b0}}) begin
            state_r   <= ST_ACCUM;
            acc_cnt_r <= {AW{1'b0}};
            up_cnt_r  <= {CW{1'b0}};
            dn_cnt_r  <= {CW{1'b0}};
          end else begin
            settle_cnt_r <= settle_cnt_r - SW'(1);
          end
        end
        ST_ACCUM: begin
          // 00 and 11 are indeterminate and count toward neither side.
          if (u_sync_s && !d_sync_s) begin
            up_cnt_r <= up_cnt_r + CW'(1);
          end else if (!u_sync_s && d_sync_s) begin
            dn_cnt_r <= dn_cnt_r + CW'(1);
          end else begin
            up_cnt_r <= up_cnt_r;
          end
          if (acc_cnt_r == ACC_LAST) begin
            state_r <= ST_DECIDE;
          end else begin
            acc_cnt_r <= acc_cnt_r + AW'(1);
          end
        end
        ST_DECIDE: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= SETTLE_LOAD;
`ifdef INV_FB_LOCK_EN
          if (lock_hit_s) begin
            state_r <= ST_LOCKED;
          end else begin
            invu_r <= (dir_s == DIR_UP);
            invd_r <= (dir_s == DIR_DOWN);
            bal_r  <= (dir_s == DIR_NONE);
          end
`else
          invu_r <= (dir_s == DIR_UP);
          invd_r <= (dir_s == DIR_DOWN);
          bal_r  <= (dir_s == DIR_NONE);
`endif
        end
`ifdef INV_FB_LOCK_EN
        ST_LOCKED: begin
          state_r <= ST_LOCKED;
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_INVU = invu_r;
  assign O_INVD = invd_r;
  assign BAL    = bal_r;

endmodule

// File: doc/inv_fb_filter.md
# inv_fb_filter

Feedback qualifier that sits directly upstream of the 4-bit inverter configuration stage. It synchronizes the raw comparator outputs from the analog inverter pair and integrates them over a fixed window. After each window it issues at most one single-cycle step request, O_INVU or O_INVD, so the configuration stage advances exactly one code per decision instead of one per clock. An analog settle interval follows every decision. Optional dither-lock detection stops stepping once the loop oscillates around its target.

## Interface
- WIN_LEN, 16: samples integrated per decision window (≥2)
- SETTLE_CYC, 8: idle cycles after each decision before sampling resumes (≥1)
- THRESH, 4: minimum |up − down| count difference to issue a step (1..WIN_LEN)
- LOCK_REV, 3: consecutive direction reversals that declare lock (≥1)

- CLK  in  1  single clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- EN  in  1  loop enable; low forces IDLE
- CMP_U  in  1  raw comparator "pull up" indication, asynchronous to CLK
- CMP_D  in  1  raw comparator "pull down" indication, asynchronous to CLK
- O_INVU  out  1  one-cycle step-up request to the configuration stage
- O_INVD  out  1  one-cycle step-down request to the configuration stage
- BAL  out  1  one-cycle pulse: window balanced, no step issued
- LOCKED  out  1  level: dither lock declared

## Operation
- CMP_U and CMP_D each pass through a 2-flop synchronizer. All counting uses the synchronized values, which lag the pins by 2 cycles.
- States:
  - IDLE: EN=1 moves to SETTLE. The settle counter loads SETTLE_CYC−1.
  - SETTLE: counts down. At 0, moves to ACCUM and clears up_cnt and dn_cnt.
  - ACCUM: runs for WIN_LEN cycles.
    - Sync U=1, D=0 increments up_cnt.
    - Sync U=0, D=1 increments dn_cnt.
    - 00 and 11 count nothing.
    - After the WIN_LEN-th sample, moves to DECIDE.
  - DECIDE: lasts one cycle.
    - If up_cnt ≥ dn_cnt + THRESH, the decision is UP.
    - Else if dn_cnt ≥ up_cnt + THRESH, the decision is DOWN.
    - Otherwise the decision is BAL.
    - Moves to SETTLE, or to LOCKED (see Configuration).
  - LOCKED: holds until EN=0 or RST.
- Counter widths are $clog2(WIN_LEN+1). Threshold compares are done one bit wider so the arithmetic cannot overflow.
- O_INVU, O_INVD and BAL are registers. At most one of them is high in any cycle. O_INVU=O_INVD=1 never occurs.
- Reversal tracking:
  - last_dir is NONE, UP or DOWN.
  - An UP or DOWN decision opposite to last_dir increments rev_cnt.
  - A decision in the same direction as last_dir clears rev_cnt.
  - BAL leaves both last_dir and rev_cnt unchanged.
- EN=0 in any state: IDLE on the next edge. Counters, rev_cnt and last_dir clear, and the outputs go to 0 on that edge, including a pulse in flight.
- RST behaves the same as EN=0, and also clears LOCKED and the synchronizer flops.

## Timing
- Reset value of every output is 0. State resets to IDLE.
- EN is sampled high at edge k:
  - SETTLE covers cycles k..k+SETTLE_CYC−1.
  - ACCUM covers the next WIN_LEN cycles.
  - DECIDE is at k+SETTLE_CYC+WIN_LEN.
  - The decision pulse is high for exactly one cycle, the cycle after DECIDE. That cycle is also the first SETTLE cycle.
- Decision period is SETTLE_CYC+WIN_LEN+1 cycles. With the defaults, pulses appear at k+25, k+50, and so on.
- The configuration stage consumes O_INVU/O_INVD on the same edge that ends the pulse. No handshake or back-pressure is involved.
- While LOCKED is high, O_INVU, O_INVD and BAL stay 0.

## Configuration
- INV_FB_LOCK_EN defined:
  - When a DECIDE produces rev_cnt == LOCK_REV, its step pulse is suppressed.
  - LOCKED rises in the cycle after that DECIDE and the state moves to LOCKED.
- INV_FB_LOCK_EN undefined:
  - LOCKED is tied to 0.
  - The LOCKED state and rev_cnt logic are removed.
  - The FSM cycles SETTLE→ACCUM→DECIDE indefinitely.

## Structure
- Shared package inv_fb_pkg holds:
  - the state enum (IDLE, SETTLE, ACCUM, DECIDE, LOCKED);
  - the direction enum (NONE, UP, DOWN);
  - the default parameter constants.
- One sub-module: inv_fb_sync2, a 2-flop synchronizer with synchronous reset. It is instantiated once per comparator bit.

## Test plan
- Reset, then EN=1 at edge 0 with CMP_U=1, CMP_D=0 held → O_INVU high only in cycles 25, 50, 75; O_INVD and BAL stay 0.
- Window with 10 samples U=1,D=0 and 6 samples U=0,D=1 → O_INVD=0 and O_INVU pulses (diff 4). A 9/7 window → BAL pulses and no step.
- Windows alternating UP, DOWN, UP, DOWN with INV_FB_LOCK_EN defined → pulses for decisions 1–3, none for decision 4. LOCKED=1 from the cycle after the 4th DECIDE. Without the macro, all 4 pulses occur and LOCKED stays 0.
- EN dropped on the 8th ACCUM cycle → IDLE next edge, no pulse. EN re-raised at edge m → first pulse at m+25.
- RST asserted during the O_INVU pulse cycle → all outputs 0 from the next cycle. LOCKED clears. Sync flops clear, so the first two post-reset samples count nothing.
- CMP_U=CMP_D=1 for a full window → both counts 0 and BAL pulses.
